// File: rtl/bsg_cgol_pkg.sv
// Shared types and sizing helpers for the Game of Life core.
// Used by the input loader and the output serializer.
package bsg_cgol_pkg;

  typedef enum logic [1:0] {
    S_FRAMES = 2'd0,
    S_BOARD  = 2'd1,
    S_DONE   = 2'd2
  } loader_state_e;

  // Returns 1 for x <= 1 so that single-entry fields still get one bit.
  function automatic int unsigned safe_clog2(input int unsigned x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

  function automatic int unsigned words_per_board(input int unsigned board_bits,
                                                  input int unsigned data_width);
    return (board_bits + data_width - 1) / data_width;
  endfunction

endpackage

// File: rtl/bsg_cgol_word_counter.sv
// Up-counter with clear, enable and terminal-count flag.
// After the terminal value it wraps to zero, so it never reaches els_p.
module bsg_cgol_word_counter
  import bsg_cgol_pkg::*;
#(
  parameter int unsigned els_p   = 4,
  parameter int unsigned width_p = safe_clog2(els_p)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clr_i,
  input  logic               en_i,
  output logic [width_p-1:0] cnt_o,
  output logic               tc_o
);

  logic [width_p-1:0] r_cnt;

  assign tc_o  = (r_cnt == width_p'(els_p - 1));
  assign cnt_o = r_cnt;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)   r_cnt <= '0;
    else if (clr_i)   r_cnt <= '0;
    else if (en_i)    r_cnt <= tc_o ? '0 : r_cnt + width_p'(1);
  end

endmodule

// File: rtl/bsg_cgol_input_loader.sv
// Collects a frame-count word and the packed initial board from the host link,
// then offers the assembled board downstream over a valid/ready handshake.
module bsg_cgol_input_loader
  import bsg_cgol_pkg::*;
#(
  parameter  int unsigned board_width_p     = 8,
  parameter  int unsigned max_game_length_p = 1024,
  parameter  int unsigned data_width_p      = 64,
  localparam int unsigned game_len_width_lp = safe_clog2(max_game_length_p),
  localparam int unsigned board_bits_lp     = board_width_p * board_width_p,
  localparam int unsigned words_lp          = words_per_board(board_bits_lp, data_width_p),
  localparam int unsigned cnt_width_lp      = safe_clog2(words_lp)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [data_width_p-1:0]      data_i,
  input  logic                         v_i,
  output logic                         ready_o,
  output logic [game_len_width_lp-1:0] frames_o,
  output logic [board_bits_lp-1:0]     board_o,
  output logic                         v_o,
  input  logic                         ready_i
);

  loader_state_e                r_state, w_state_next;
  logic                         w_frame_xfer, w_board_xfer, w_last_word;
  logic [cnt_width_lp-1:0]      w_cnt;
  logic [game_len_width_lp-1:0] r_frames;
  logic [board_bits_lp-1:0]     r_board, w_board_next;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= S_FRAMES;
    else            r_state <= w_state_next;
  end

  // Handshake outputs depend on the state register only.
  always_comb begin
    w_state_next = r_state;
    ready_o      = 1'b0;
    v_o          = 1'b0;
    w_frame_xfer = 1'b0;
    w_board_xfer = 1'b0;
    case (r_state)
      S_FRAMES: begin
        ready_o = 1'b1;
        if (v_i) begin
          w_frame_xfer = 1'b1;
          w_state_next = S_BOARD;
        end
      end
      S_BOARD: begin
        ready_o = 1'b1;
        if (v_i) begin
          w_board_xfer = 1'b1;
          if (w_last_word) w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        v_o = 1'b1;
        if (ready_i) w_state_next = S_FRAMES;
      end
      default: w_state_next = S_FRAMES;
    endcase
  end

  bsg_cgol_word_counter #(
    .els_p   (words_lp),
    .width_p (cnt_width_lp)
  ) u_word_counter (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clr_i     (w_frame_xfer),
    .en_i      (w_board_xfer),
    .cnt_o     (w_cnt),
    .tc_o      (w_last_word)
  );

  // The last slice is narrowed so link bits past the board edge are dropped.
  for (genvar w = 0; w < words_lp; w++) begin : g_word
    localparam int unsigned lo  = w * data_width_p;
    localparam int unsigned len = ((board_bits_lp - lo) < data_width_p) ?
                                  (board_bits_lp - lo) : data_width_p;
    assign w_board_next[lo +: len] = (w_cnt == cnt_width_lp'(w)) ?
                                     data_i[len-1:0] : r_board[lo +: len];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_frames <= '0;
      r_board  <= '0;
    end else begin
      if (w_frame_xfer) r_frames <= data_i[game_len_width_lp-1:0];
      if (w_board_xfer) r_board  <= w_board_next;
    end
  end

  assign frames_o = r_frames;
  assign board_o  = r_board;

endmodule
